// File: rtl/axi4_stream_pkt_gen_pkg.sv
// Shared types and constants for the AXI4-Stream packet generator.
package axi4_stream_pkt_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap
  } pkt_gen_state_t;

  // Galois LFSR used for optional random bubbles
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Widest keep vector the mask helper can produce (1024-bit data)
  localparam int unsigned MaxKeepW = 128;

  // Keep mask for the final word: low 'rem' bytes valid, all bytes when rem is 0
  function automatic logic [MaxKeepW-1:0] last_keep_mask(input int rem);
    logic [MaxKeepW-1:0] m;
    m = '0;
    if (rem == 0) begin
      m = '1;
    end else begin
      for (int i = 0; i < MaxKeepW; i++) begin
        if (i < rem) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// AXI4-Stream bundle with master/slave views.
interface axi4_stream_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1
);
  logic                    tvalid;
  logic                    tready;
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic                    tlast;
  logic [USER_WIDTH-1:0]   tuser;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [ID_WIDTH-1:0]     tid;

  modport master (
    output tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tdest, tid,
    output tready
  );
endinterface

// File: rtl/axi4_stream_pkt_gen_lfsr16.sv
// 16-bit Galois LFSR; only built when AXI4_STREAM_PKT_GEN_RANDOM_GAPS_EN is defined.
`ifdef AXI4_STREAM_PKT_GEN_RANDOM_GAPS_EN
module lfsr16
  import axi4_stream_pkt_gen_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  output logic [15:0] value_o
);

  logic [15:0] lfsr_q, lfsr_d;

  // Shift right, folding the taps in when the dropped bit is set
  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LfsrTaps) : (lfsr_q >> 1);
  end

  // LFSR state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) lfsr_q <= LfsrSeed;
    else          lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule
`endif

// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream numbered-packet generator with backpressure, gaps and stop control.
// Optional random intra-packet bubbles: define AXI4_STREAM_PKT_GEN_RANDOM_GAPS_EN.
module axi4_stream_pkt_gen
  import axi4_stream_pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] pkt_len_i,
  input  logic [CNT_WIDTH-1:0] pkt_num_i,
  input  logic [7:0]           ifg_i,
  input  logic                 stop_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] sent_pkts_o,
  axi4_stream_if.master        pkt_o
);

  localparam int unsigned DataWidthB = DATA_WIDTH / 8;
  localparam int unsigned WordW      = LEN_WIDTH + 1;
  localparam int unsigned OffW       = LEN_WIDTH + 9;

  pkt_gen_state_t          state_q, state_d;
  logic [WordW-1:0]        words_q, words_d;
  logic [DataWidthB-1:0]   last_keep_q, last_keep_d;
  logic [CNT_WIDTH-1:0]    num_q, num_d;
  logic [7:0]              ifg_q, ifg_d;
  logic [WordW-1:0]        word_idx_q, word_idx_d;
  logic [CNT_WIDTH-1:0]    pkt_idx_q, pkt_idx_d;
  logic [CNT_WIDTH-1:0]    sent_q, sent_d;
  logic                    stop_pend_q, stop_pend_d;
  logic [7:0]              gap_cnt_q, gap_cnt_d;
  logic                    done_q, done_d;
  logic                    tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [DataWidthB-1:0]   tkeep_q, tkeep_d;
  logic                    tlast_q, tlast_d;
  logic [USER_WIDTH-1:0]   tuser_q, tuser_d;
  logic [DEST_WIDTH-1:0]   tdest_q, tdest_d;

  logic                    offer_ok;
  logic                    load_en;
  logic [CNT_WIDTH-1:0]    load_pkt;
  logic [WordW-1:0]        load_word;
  logic                    ld_last;
  logic [WordW-1:0]        words_calc;
  logic [LEN_WIDTH-1:0]    len_rem;
  logic [MaxKeepW-1:0]     keep_full;

  // Byte k of packet p is p[7:0] + k; word w starts at k = w * DataWidthB
  function automatic logic [DATA_WIDTH-1:0] word_data(input logic [7:0]       p,
                                                      input logic [WordW-1:0] w);
    logic [OffW-1:0]       off;
    logic [DATA_WIDTH-1:0] d;
    off = OffW'(w) * OffW'(DataWidthB);
    d   = '0;
    for (int j = 0; j < DataWidthB; j++) begin
      d[j*8 +: 8] = p + off[7:0] + 8'(j);
    end
    return d;
  endfunction

`ifdef AXI4_STREAM_PKT_GEN_RANDOM_GAPS_EN
  logic [15:0] lfsr_value;
  logic        unused_lfsr;

  lfsr16 u_lfsr (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .en_i    (1'b1),
    .value_o (lfsr_value)
  );

  assign offer_ok    = lfsr_value[0];
  assign unused_lfsr = ^lfsr_value[15:1];
`else
  assign offer_ok = 1'b1;
`endif

  // Extra bit keeps the round-up from overflowing at maximum length
  assign words_calc = (WordW'(pkt_len_i) + WordW'(DataWidthB - 1)) / WordW'(DataWidthB);
  assign len_rem    = pkt_len_i % LEN_WIDTH'(DataWidthB);
  assign keep_full  = last_keep_mask(int'(len_rem));
  assign ld_last    = (load_word == words_q - WordW'(1));

  // Next-state, handshake and payload selection
  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    last_keep_d = last_keep_q;
    num_d       = num_q;
    ifg_d       = ifg_q;
    word_idx_d  = word_idx_q;
    pkt_idx_d   = pkt_idx_q;
    sent_d      = sent_q;
    gap_cnt_d   = gap_cnt_q;
    done_d      = 1'b0;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    tuser_d     = tuser_q;
    tdest_d     = tdest_q;
    load_en     = 1'b0;
    load_pkt    = pkt_idx_q;
    load_word   = word_idx_q;
    stop_pend_d = stop_pend_q | ((state_q != StIdle) & stop_i);

    unique case (state_q)
      StIdle: begin
        if (start_i && (pkt_len_i != '0)) begin
          words_d     = words_calc;
          last_keep_d = keep_full[DataWidthB-1:0];
          num_d       = pkt_num_i;
          ifg_d       = ifg_i;
          sent_d      = '0;
          pkt_idx_d   = '0;
          word_idx_d  = '0;
          stop_pend_d = 1'b0;
          state_d     = StSend;
        end
      end

      StSend: begin
        if (!tvalid_q) begin
          if (offer_ok) begin
            load_en  = 1'b1;
            tvalid_d = 1'b1;
          end
        end else if (pkt_o.tready) begin
          if (!tlast_q) begin
            word_idx_d = word_idx_q + WordW'(1);
            load_word  = word_idx_q + WordW'(1);
            if (offer_ok) load_en = 1'b1;
            else          tvalid_d = 1'b0;
          end else begin
            sent_d     = sent_q + CNT_WIDTH'(1);
            pkt_idx_d  = pkt_idx_q + CNT_WIDTH'(1);
            word_idx_d = '0;
            if (((num_q != '0) && (sent_q + CNT_WIDTH'(1) == num_q)) || stop_pend_q || stop_i) begin
              state_d     = StIdle;
              tvalid_d    = 1'b0;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end else if (ifg_q == 8'd0) begin
              // Back-to-back packets: next packet's first word replaces the accepted tlast
              load_pkt  = pkt_idx_q + CNT_WIDTH'(1);
              load_word = '0;
              if (offer_ok) load_en = 1'b1;
              else          tvalid_d = 1'b0;
            end else begin
              state_d   = StGap;
              gap_cnt_d = ifg_q;
              tvalid_d  = 1'b0;
            end
          end
        end
      end

      StGap: begin
        if (stop_pend_q || stop_i) begin
          state_d     = StIdle;
          done_d      = 1'b1;
          stop_pend_d = 1'b0;
        end else if (gap_cnt_q <= 8'd1) begin
          // Load on the last idle cycle so tvalid rises right after ifg low cycles
          state_d = StSend;
          if (offer_ok) begin
            load_en  = 1'b1;
            tvalid_d = 1'b1;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (load_en) begin
      tdata_d = word_data(load_pkt[7:0], load_word);
      tkeep_d = ld_last ? last_keep_q : '1;
      tlast_d = ld_last;
      tuser_d = USER_WIDTH'(load_word == '0);
      tdest_d = load_pkt[DEST_WIDTH-1:0];
    end
  end

  // State and registered stream outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      words_q     <= '0;
      last_keep_q <= '0;
      num_q       <= '0;
      ifg_q       <= '0;
      word_idx_q  <= '0;
      pkt_idx_q   <= '0;
      sent_q      <= '0;
      stop_pend_q <= 1'b0;
      gap_cnt_q   <= '0;
      done_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
      tuser_q     <= '0;
      tdest_q     <= '0;
    end else begin
      state_q     <= state_d;
      words_q     <= words_d;
      last_keep_q <= last_keep_d;
      num_q       <= num_d;
      ifg_q       <= ifg_d;
      word_idx_q  <= word_idx_d;
      pkt_idx_q   <= pkt_idx_d;
      sent_q      <= sent_d;
      stop_pend_q <= stop_pend_d;
      gap_cnt_q   <= gap_cnt_d;
      done_q      <= done_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      tdest_q     <= tdest_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign sent_pkts_o = sent_q;

  assign pkt_o.tvalid = tvalid_q;
  assign pkt_o.tdata  = tdata_q;
  assign pkt_o.tkeep  = tkeep_q;
  assign pkt_o.tstrb  = tkeep_q;
  assign pkt_o.tlast  = tlast_q;
  assign pkt_o.tuser  = tuser_q;
  assign pkt_o.tdest  = tdest_q;
  assign pkt_o.tid    = '0;

endmodule
